ctrl_unit_v2: RTL and testbench

CTRL_UNIT_V2 -- requirements
Module: ctrl_unit_v2

---
 rtl/ctrl_unit_v2.sv | 201 ++++++++++++++++++++
 tb/tb_ctrl_unit_v2.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit_v2.sv
// rtl/ctrl_unit_v2.sv - multi-cycle Moore control FSM with memory wait counter and trap handling
// Per-instruction variants of R_EXEC, MEM_ADDR and WB are separate states so all strobes stay state-decoded.
module ctrl_unit_v2 #(
  parameter int MEM_WAIT = 2,
  parameter int OVF_TRAP = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       memory_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       alu_out_write,
  output logic       epc_write,
  output logic       invalid_op
);

  localparam int CW = $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] FETCH_LAST = CW'((MEM_WAIT >= 2) ? MEM_WAIT - 2 : 0);
  localparam logic [CW-1:0] MEM_LAST   = CW'(MEM_WAIT - 1);

  localparam logic [4:0] S_FETCH    = 5'd0;
  localparam logic [4:0] S_IR_LOAD  = 5'd1;
  localparam logic [4:0] S_DECODE   = 5'd2;
  localparam logic [4:0] S_R_ADD    = 5'd3;
  localparam logic [4:0] S_R_SUB    = 5'd4;
  localparam logic [4:0] S_R_AND    = 5'd5;
  localparam logic [4:0] S_ADDI     = 5'd6;
  localparam logic [4:0] S_MEM_LW   = 5'd7;
  localparam logic [4:0] S_MEM_SW   = 5'd8;
  localparam logic [4:0] S_LW_READ  = 5'd9;
  localparam logic [4:0] S_SW_WRITE = 5'd10;
  localparam logic [4:0] S_WB_R     = 5'd11;
  localparam logic [4:0] S_WB_I     = 5'd12;
  localparam logic [4:0] S_WB_LW    = 5'd13;
  localparam logic [4:0] S_BEQ      = 5'd14;
  localparam logic [4:0] S_JUMP     = 5'd15;
  localparam logic [4:0] S_EXC      = 5'd16;

  // With single-cycle memory there is nothing to wait for, so instructions chain straight into IR_LOAD.
  localparam logic [4:0] S_RESTART = (MEM_WAIT == 1) ? S_IR_LOAD : S_FETCH;
  localparam bit TRAP_EN = (OVF_TRAP != 0);

  logic [4:0]    state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          invalid_op_q, invalid_op_d;

  // alu_zero is consumed by the datapath through pc_write_cond, not by the sequencer.
  logic unused;
  assign unused = alu_zero;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    invalid_op_d = invalid_op_q;
    case (state_q)
      S_FETCH: begin
        if (wait_cnt_q == FETCH_LAST) state_d = S_IR_LOAD;
        else wait_cnt_d = wait_cnt_q + CW'(1);
      end
      S_IR_LOAD: state_d = S_DECODE;
      S_DECODE: begin
        case (op_code)
          6'b000000: begin
            case (funct)
              6'b100000: state_d = S_R_ADD;
              6'b100010: state_d = S_R_SUB;
              6'b100100: state_d = S_R_AND;
              default: begin
                state_d      = S_EXC;
                invalid_op_d = 1'b1;
              end
            endcase
          end
          6'b001000: state_d = S_ADDI;
          6'b100011: state_d = S_MEM_LW;
          6'b101011: state_d = S_MEM_SW;
          6'b000100: state_d = S_BEQ;
          6'b000010: state_d = S_JUMP;
          default: begin
            state_d      = S_EXC;
            invalid_op_d = 1'b1;
          end
        endcase
      end
      S_R_ADD, S_R_SUB: state_d = (TRAP_EN && overflow) ? S_EXC : S_WB_R;
      S_R_AND:          state_d = S_WB_R;
      S_ADDI:           state_d = (TRAP_EN && overflow) ? S_EXC : S_WB_I;
      S_MEM_LW:         state_d = S_LW_READ;
      S_MEM_SW:         state_d = S_SW_WRITE;
      S_LW_READ: begin
        if (wait_cnt_q == MEM_LAST) state_d = S_WB_LW;
        else wait_cnt_d = wait_cnt_q + CW'(1);
      end
      S_SW_WRITE: begin
        if (wait_cnt_q == MEM_LAST) state_d = S_RESTART;
        else wait_cnt_d = wait_cnt_q + CW'(1);
      end
      S_WB_R, S_WB_I, S_WB_LW, S_BEQ, S_JUMP, S_EXC: state_d = S_RESTART;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= '0;
      invalid_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      invalid_op_q <= invalid_op_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    i_or_d        = 1'b0;
    memory_write  = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 3'b000;
    alu_out_write = 1'b0;
    epc_write     = 1'b0;
    case (state_q)
      S_IR_LOAD: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = 3'b001;
      end
      S_DECODE: begin
        alu_src_b     = 2'd3;
        alu_op        = 3'b001;
        alu_out_write = 1'b1;
      end
      S_R_ADD, S_R_SUB, S_R_AND: begin
        alu_src_a     = 1'b1;
        alu_op        = (state_q == S_R_ADD) ? 3'b001 : (state_q == S_R_SUB) ? 3'b010 : 3'b011;
        alu_out_write = 1'b1;
      end
      S_ADDI, S_MEM_LW, S_MEM_SW: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'd2;
        alu_op        = 3'b001;
        alu_out_write = 1'b1;
      end
      S_LW_READ: i_or_d = 1'b1;
      S_SW_WRITE: begin
        i_or_d       = 1'b1;
        memory_write = 1'b1;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_WB_I: reg_write = 1'b1;
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b010;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      S_EXC: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_source = 2'd3;
      end
      default: ;
    endcase
  end

  assign invalid_op = invalid_op_q;

endmodule

// File: tb/tb_ctrl_unit_v2.sv
// tb/tb_ctrl_unit_v2.sv - directed-vector bench for ctrl_unit_v2 (one MEM_WAIT=2 trapping and one MEM_WAIT=3 non-trapping instance)
module tb_ctrl_unit_v2;

  logic       clock, reset, alu_zero, overflow;
  logic [5:0] op_code, funct;

  logic       a_pc_write, a_pc_write_cond, a_i_or_d, a_memory_write, a_ir_write, a_reg_write;
  logic       a_reg_dst, a_mem_to_reg, a_alu_src_a, a_alu_out_write, a_epc_write, a_invalid_op;
  logic [1:0] a_pc_source, a_alu_src_b;
  logic [2:0] a_alu_op;
  logic       b_pc_write, b_pc_write_cond, b_i_or_d, b_memory_write, b_ir_write, b_reg_write;
  logic       b_reg_dst, b_mem_to_reg, b_alu_src_a, b_alu_out_write, b_epc_write, b_invalid_op;
  logic [1:0] b_pc_source, b_alu_src_b;
  logic [2:0] b_alu_op;

  ctrl_unit_v2 #(.MEM_WAIT(2), .OVF_TRAP(1)) u_a (
    .clock(clock), .reset(reset), .op_code(op_code), .funct(funct),
    .alu_zero(alu_zero), .overflow(overflow),
    .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond), .pc_source(a_pc_source),
    .i_or_d(a_i_or_d), .memory_write(a_memory_write), .ir_write(a_ir_write),
    .reg_write(a_reg_write), .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
    .alu_out_write(a_alu_out_write), .epc_write(a_epc_write), .invalid_op(a_invalid_op)
  );

  ctrl_unit_v2 #(.MEM_WAIT(3), .OVF_TRAP(0)) u_b (
    .clock(clock), .reset(reset), .op_code(op_code), .funct(funct),
    .alu_zero(alu_zero), .overflow(overflow),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .pc_source(b_pc_source),
    .i_or_d(b_i_or_d), .memory_write(b_memory_write), .ir_write(b_ir_write),
    .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
    .alu_out_write(b_alu_out_write), .epc_write(b_epc_write), .invalid_op(b_invalid_op)
  );

  logic [17:0] a_ctl, b_ctl;
  assign a_ctl = {a_pc_write, a_pc_write_cond, a_pc_source, a_i_or_d, a_memory_write, a_ir_write,
                  a_reg_write, a_reg_dst, a_mem_to_reg, a_alu_src_a, a_alu_src_b, a_alu_op,
                  a_alu_out_write, a_epc_write};
  assign b_ctl = {b_pc_write, b_pc_write_cond, b_pc_source, b_i_or_d, b_memory_write, b_ir_write,
                  b_reg_write, b_reg_dst, b_mem_to_reg, b_alu_src_a, b_alu_src_b, b_alu_op,
                  b_alu_out_write, b_epc_write};

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] e_fetch, e_irl, e_dec, e_add, e_sub, e_and, e_imm, e_lw, e_sw;
  logic [17:0] e_wbr, e_wbi, e_wblw, e_beq, e_jmp, e_exc;

  always #5 clock = ~clock;

  function automatic logic [17:0] cw(input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                     input logic iod, input logic mw, input logic irw,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic asa, input logic [1:0] asb, input logic [2:0] aop,
                                     input logic aow, input logic epc);
    return {pcw, pcwc, pcs, iod, mw, irw, rw, rd, m2r, asa, asb, aop, aow, epc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input bit use_b, input logic [17:0] exp);
    @(posedge clock);
    @(negedge clock);
    chk(tag, 32'(use_b ? b_ctl : a_ctl), 32'(exp));
  endtask

  task automatic do_reset(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
    @(negedge clock);
    op_code  = op;
    funct    = fn;
    overflow = ovf;
    reset    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("rst_a_ctl", 32'(a_ctl), 32'd0);
    chk("rst_b_ctl", 32'(b_ctl), 32'd0);
    chk("rst_inv", 32'({a_invalid_op, b_invalid_op}), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    clock = 0; reset = 1; op_code = 0; funct = 0; alu_zero = 0; overflow = 0;
    e_fetch = '0;
    e_irl  = cw(1, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 2'd1, 3'b001, 0, 0);
    e_dec  = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 3'b001, 1, 0);
    e_add  = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'b001, 1, 0);
    e_sub  = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'b010, 1, 0);
    e_and  = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'b011, 1, 0);
    e_imm  = cw(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'b001, 1, 0);
    e_lw   = cw(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 2'd0, 3'b000, 0, 0);
    e_sw   = cw(0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 3'b000, 0, 0);
    e_wbr  = cw(0, 0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 2'd0, 3'b000, 0, 0);
    e_wbi  = cw(0, 0, 2'd0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 3'b000, 0, 0);
    e_wblw = cw(0, 0, 2'd0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 3'b000, 0, 0);
    e_beq  = cw(0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'b010, 0, 0);
    e_jmp  = cw(1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b000, 0, 0);
    e_exc  = cw(1, 0, 2'd3, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'b000, 0, 1);

    // R-type add, W=2: next FETCH lands in the 5th cycle counting IR_LOAD as the 1st
    do_reset(6'b000000, 6'b100000, 1'b0);
    step("add_irl", 0, e_irl);
    step("add_dec", 0, e_dec);
    step("add_exec", 0, e_add);
    step("add_wb", 0, e_wbr);
    step("add_fetch", 0, e_fetch);
    step("add_irl2", 0, e_irl);

    // lw, W=3: two FETCH cycles, three LW_READ cycles
    do_reset(6'b100011, 6'b000000, 1'b0);
    step("lw_fetch2", 1, e_fetch);
    step("lw_irl", 1, e_irl);
    step("lw_dec", 1, e_dec);
    step("lw_addr", 1, e_imm);
    step("lw_rd1", 1, e_lw);
    step("lw_rd2", 1, e_lw);
    step("lw_rd3", 1, e_lw);
    step("lw_wb", 1, e_wblw);
    step("lw_fetch", 1, e_fetch);

    // beq taken and not taken produce identical strobes
    for (int z = 1; z >= 0; z--) begin
      alu_zero = z[0];
      do_reset(6'b000100, 6'b000000, 1'b0);
      step("beq_irl", 0, e_irl);
      step("beq_dec", 0, e_dec);
      step("beq_exec", 0, e_beq);
      step("beq_fetch", 0, e_fetch);
    end
    alu_zero = 0;

    // jump
    do_reset(6'b000010, 6'b000000, 1'b0);
    step("j_irl", 0, e_irl);
    step("j_dec", 0, e_dec);
    step("j_exec", 0, e_jmp);
    step("j_fetch", 0, e_fetch);

    // addi overflow traps with OVF_TRAP=1
    do_reset(6'b001000, 6'b000000, 1'b1);
    step("addi_irl", 0, e_irl);
    step("addi_dec", 0, e_dec);
    step("addi_exec", 0, e_imm);
    step("addi_trap", 0, e_exc);
    step("addi_trap_fetch", 0, e_fetch);
    chk("addi_trap_inv", 32'(a_invalid_op), 32'd0);

    // addi overflow ignored with OVF_TRAP=0
    do_reset(6'b001000, 6'b000000, 1'b1);
    step("addi_nt_fetch2", 1, e_fetch);
    step("addi_nt_irl", 1, e_irl);
    step("addi_nt_dec", 1, e_dec);
    step("addi_nt_exec", 1, e_imm);
    step("addi_nt_wb", 1, e_wbi);

    // sub overflow traps, and overflow never traps
    do_reset(6'b000000, 6'b100010, 1'b1);
    step("sub_irl", 0, e_irl);
    step("sub_dec", 0, e_dec);
    step("sub_exec", 0, e_sub);
    step("sub_trap", 0, e_exc);
    do_reset(6'b000000, 6'b100100, 1'b1);
    step("and_irl", 0, e_irl);
    step("and_dec", 0, e_dec);
    step("and_exec", 0, e_and);
    step("and_wb", 0, e_wbr);

    // unsupported funct under op 000000
    do_reset(6'b000000, 6'b100101, 1'b0);
    step("badfn_irl", 0, e_irl);
    step("badfn_dec", 0, e_dec);
    step("badfn_exc", 0, e_exc);
    chk("badfn_inv", 32'(a_invalid_op), 32'd1);

    // invalid op is sticky through a valid add, cleared by reset mid-SW_WRITE
    do_reset(6'b111111, 6'b000000, 1'b0);
    step("inv_irl", 0, e_irl);
    step("inv_dec", 0, e_dec);
    step("inv_exc", 0, e_exc);
    chk("inv_set", 32'(a_invalid_op), 32'd1);
    op_code = 6'b000000; funct = 6'b100000;
    step("inv_fetch", 0, e_fetch);
    step("inv_add_irl", 0, e_irl);
    step("inv_add_dec", 0, e_dec);
    step("inv_add_exec", 0, e_add);
    step("inv_add_wb", 0, e_wbr);
    chk("inv_sticky", 32'(a_invalid_op), 32'd1);
    op_code = 6'b101011;
    step("sw_fetch", 0, e_fetch);
    step("sw_irl", 0, e_irl);
    step("sw_dec", 0, e_dec);
    step("sw_addr", 0, e_imm);
    step("sw_wr1", 0, e_sw);
    step("sw_wr2", 0, e_sw);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("sw_rst_ctl", 32'(a_ctl), 32'd0);
    chk("sw_rst_mw", 32'(a_memory_write), 32'd0);
    chk("sw_rst_inv", 32'(a_invalid_op), 32'd0);
    reset = 1'b0;
    step("post_rst_irl", 0, e_irl);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
